wb_scoreboard: RTL

- Write-side companion of the 32x64 register file in the pipelined LEGv8 core.
- Contains the MEM/WB pipeline register and generates the register-file write port (we3, wa3, wd3).
- Keeps a per-register scoreboard of in-flight destination writes and stalls decode when a source register still has a write pending.
- Decode (issue) side and memory-stage side connect on the inputs; the register file connects on the write outputs.

---
 rtl/wb_scoreboard_if.sv | 44 ++++
 rtl/wb_scoreboard.sv | 85 ++++++++
 2 files changed

// File: rtl/wb_scoreboard_if.sv
// Decode, memory-stage and register-file write signals
// shared between wb_scoreboard and its neighbours.
interface wb_scoreboard_if #(
  parameter int DW = 64,
  parameter int AW = 5
);
  logic          id_valid;
  logic          id_use1;
  logic          id_use2;
  logic [AW-1:0] id_ra1;
  logic [AW-1:0] id_ra2;
  logic          id_we;
  logic [AW-1:0] id_wa;
  logic          stall;

  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic          mem_memtoreg;
  logic [DW-1:0] mem_alu;
  logic [DW-1:0] mem_rdata;

  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic          busy;
  logic          sb_err;

  modport master (
    output id_valid, id_use1, id_use2,
    output id_ra1, id_ra2, id_we, id_wa,
    output mem_valid, mem_we, mem_wa,
    output mem_memtoreg, mem_alu, mem_rdata,
    input  stall, we3, wa3, wd3, busy, sb_err
  );

  modport slave (
    input  id_valid, id_use1, id_use2,
    input  id_ra1, id_ra2, id_we, id_wa,
    input  mem_valid, mem_we, mem_wa,
    input  mem_memtoreg, mem_alu, mem_rdata,
    output stall, we3, wa3, wd3, busy, sb_err
  );
endinterface

// File: rtl/wb_scoreboard.sv
// MEM/WB register, register-file write port and
// per-register in-flight write scoreboard for decode stalls.
module wb_scoreboard #(
  parameter int NREG = 32,
  parameter int DW   = 64,
  parameter int CW   = 2
) (
  input logic        clk,
  input logic        reset,
  wb_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] ZR = AW'(NREG - 1);
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] nz;
  logic            stall;
  logic            issue;
  logic            err_now;

  // a retiring write is bypassed by the regfile, so it is not pending
  always_comb begin
    dec  = '0;
    pend = '0;
    nz   = '0;
    for (int r = 0; r < NREG - 1; r++) begin
      dec[r]  = bus.we3 && (bus.wa3 == AW'(r));
      nz[r]   = cnt[r] != '0;
      pend[r] = (cnt[r] - CW'(dec[r])) != '0;
    end
  end

  assign stall = bus.id_valid &
    ((bus.id_use1 & (bus.id_ra1 != ZR) & pend[bus.id_ra1]) |
     (bus.id_use2 & (bus.id_ra2 != ZR) & pend[bus.id_ra2]));

  assign issue = bus.id_valid & ~stall & bus.id_we &
                 (bus.id_wa != ZR);

  always_comb begin
    inc     = '0;
    err_now = 1'b0;
    for (int r = 0; r < NREG - 1; r++) begin
      inc[r] = issue && (bus.id_wa == AW'(r));
    end
    for (int r = 0; r < NREG - 1; r++) begin
      if (inc[r] && !dec[r] && cnt[r] == CMAX) err_now = 1'b1;
      if (dec[r] && !inc[r] && cnt[r] == '0)   err_now = 1'b1;
    end
  end

  assign bus.stall = stall;
  assign bus.busy  = |nz;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.we3    <= 1'b0;
      bus.wa3    <= '0;
      bus.wd3    <= '0;
      bus.sb_err <= 1'b0;
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      bus.we3 <= bus.mem_valid & bus.mem_we &
                 (bus.mem_wa != ZR);
      bus.wa3 <= bus.mem_wa;
      bus.wd3 <= bus.mem_memtoreg ? bus.mem_rdata
                                  : bus.mem_alu;
      bus.sb_err <= bus.sb_err | err_now;
      // saturate instead of wrapping; err_now flags the attempt
      for (int r = 0; r < NREG - 1; r++) begin
        unique case (1'b1)
          inc[r] & ~dec[r]:
            if (cnt[r] != CMAX) cnt[r] <= cnt[r] + CW'(1);
          dec[r] & ~inc[r]:
            if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
          default: ;
        endcase
      end
    end
  end
endmodule
